// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue controller: ALUOp codes, RV64 opcodes,
// branch funct3 codes, FSM state encoding and the branch condition helper.
package alu_pkg;

    localparam int unsigned ALU_DATA_W = 64;
    localparam int unsigned ALU_OP_W   = 4;

    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'b1100;
    localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'b0111;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Signed compares reuse the unsigned flags because both operands had their MSB flipped.
    function automatic logic br_taken(input logic [2:0] cond, input logic zero, input logic gt);
        logic t;
        case (cond)
            BR_BEQ:          t = zero;
            BR_BNE:          t = !zero;
            BR_BLT, BR_BLTU: t = !gt && !zero;
            BR_BGE, BR_BGEU: t = gt || zero;
            default:         t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational instruction decode: maps opcode/funct fields to ALUOp,
// operand selection, branch condition and the illegal flag.
module alu_issue_decode
    import alu_pkg::*;
(
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic                funct7_5,
    input  logic [5:0]          imm_hi,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                b_sel_imm,
    output logic                flip_msb,
    output logic                is_branch,
    output logic [2:0]          br_cond,
    output logic                illegal
);

    always_comb begin
        alu_op    = ALU_ADD;
        b_sel_imm = 1'b0;
        flip_msb  = 1'b0;
        is_branch = 1'b0;
        br_cond   = funct3;
        illegal   = 1'b0;
        case (opcode)
            OP_R: begin
                case (funct3)
                    3'b000:  alu_op = funct7_5 ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_op = ALU_AND;
                    3'b110:  alu_op = ALU_OR;
                    3'b001: begin
                        alu_op  = ALU_SLL;
                        illegal = funct7_5;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_I: begin
                b_sel_imm = 1'b1;
                case (funct3)
                    3'b000:  alu_op = ALU_ADD;
                    3'b111:  alu_op = ALU_AND;
                    3'b110:  alu_op = ALU_OR;
                    3'b001: begin
                        alu_op  = ALU_SLL;
                        illegal = (imm_hi != 6'd0);
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_LOAD, OP_STORE: begin
                b_sel_imm = 1'b1;
            end
            OP_BRANCH: begin
                alu_op    = ALU_SUB;
                is_branch = 1'b1;
                case (funct3)
                    BR_BLT, BR_BGE:                    flip_msb = 1'b1;
                    BR_BEQ, BR_BNE, BR_BLTU, BR_BGEU:  flip_msb = 1'b0;
                    default:                           illegal  = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts one decoded instruction, drives the ALU from
// registers, samples its result and presents it on a valid/ready channel.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = ALU_DATA_W,
    parameter int unsigned OP_W   = ALU_OP_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic              funct7_5,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_gt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_branch,
    output logic              out_taken,
    output logic              out_illegal
);

    logic [ALU_OP_W-1:0] dec_op;
    logic                dec_bimm;
    logic                dec_flip;
    logic                dec_br;
    logic [2:0]          dec_cond;
    logic                dec_ill;

    alu_issue_decode u_decode (
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7_5  (funct7_5),
        .imm_hi    (imm[11:6]),
        .alu_op    (dec_op),
        .b_sel_imm (dec_bimm),
        .flip_msb  (dec_flip),
        .is_branch (dec_br),
        .br_cond   (dec_cond),
        .illegal   (dec_ill)
    );

    state_e            state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic              br_q, br_d;
    logic [2:0]        cond_q, cond_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_result_q, out_result_d;
    logic              out_branch_q, out_branch_d;
    logic              out_taken_q, out_taken_d;
    logic              out_illegal_q, out_illegal_d;

    logic [DATA_W-1:0] msb_mask;

    assign msb_mask = {dec_flip, {(DATA_W-1){1'b0}}};
    assign in_ready = reset_n && (state_q == ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= '0;
            br_q          <= 1'b0;
            cond_q        <= 3'd0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_branch_q  <= 1'b0;
            out_taken_q   <= 1'b0;
            out_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            br_q          <= br_d;
            cond_q        <= cond_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_branch_q  <= out_branch_d;
            out_taken_q   <= out_taken_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    // Next-state and register-load logic; illegal encodings skip EXEC and leave the ALU untouched.
    always_comb begin
        state_d       = state_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        br_d          = br_q;
        cond_d        = cond_q;
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_branch_d  = out_branch_q;
        out_taken_d   = out_taken_q;
        out_illegal_d = out_illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    if (dec_ill) begin
                        state_d       = ST_DONE;
                        out_valid_d   = 1'b1;
                        out_result_d  = '0;
                        out_branch_d  = 1'b0;
                        out_taken_d   = 1'b0;
                        out_illegal_d = 1'b1;
                    end else begin
                        state_d  = ST_EXEC;
                        alu_a_d  = rs1_data ^ msb_mask;
                        alu_b_d  = (dec_bimm ? imm : rs2_data) ^ msb_mask;
                        alu_op_d = OP_W'(dec_op);
                        br_d     = dec_br;
                        cond_d   = dec_cond;
                    end
                end
            end
            ST_EXEC: begin
                state_d       = ST_DONE;
                out_valid_d   = 1'b1;
                out_result_d  = alu_result;
                out_branch_d  = br_q;
                out_taken_d   = br_q && br_taken(cond_q, alu_zero, alu_gt);
                out_illegal_d = 1'b0;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_branch  = out_branch_q;
    assign out_taken   = out_taken_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU in the loop, instruction-level
// reference model, per-cycle compare process and directed literal checks.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [63:0] rs1_data, rs2_data, imm;
    logic [63:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [63:0] alu_result;
    logic        alu_zero, alu_gt;
    logic        out_valid, out_ready;
    logic [63:0] out_result;
    logic        out_branch, out_taken, out_illegal;

    int total = 0;
    int bad   = 0;

    alu_issue_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .imm        (imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .alu_gt     (alu_gt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_branch (out_branch),
        .out_taken  (out_taken),
        .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The combinational 64-bit ALU the controller drives.
    always_comb begin
        case (alu_op)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b1100: alu_result = ~(alu_a | alu_b);
            4'b0111: alu_result = alu_a << alu_b[5:0];
            default: alu_result = 64'd0;
        endcase
        alu_zero = (alu_result == 64'd0);
        alu_gt   = (alu_a > alu_b);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Instruction semantics straight from the ISA, no ALUOp reasoning for the result.
    task automatic ref_exec(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                            input logic [63:0] a, input logic [63:0] b, input logic [63:0] im,
                            output logic [63:0] res, output logic br, output logic tk,
                            output logic ill, output logic [63:0] ea, output logic [63:0] eb,
                            output logic [3:0] eop);
        res = 64'd0; br = 1'b0; tk = 1'b0; ill = 1'b0;
        ea = a; eb = b; eop = 4'b0010;
        case (opc)
            7'b0110011: case (f3)
                3'b000: begin res = f75 ? a - b : a + b; eop = f75 ? 4'b0110 : 4'b0010; end
                3'b111: begin res = a & b; eop = 4'b0000; end
                3'b110: begin res = a | b; eop = 4'b0001; end
                3'b001: begin ill = f75; res = a << b[5:0]; eop = 4'b0111; end
                default: ill = 1'b1;
            endcase
            7'b0010011: begin
                eb = im;
                case (f3)
                    3'b000: res = a + im;
                    3'b111: begin res = a & im; eop = 4'b0000; end
                    3'b110: begin res = a | im; eop = 4'b0001; end
                    3'b001: begin ill = (im[11:6] != 6'd0); res = a << im[5:0]; eop = 4'b0111; end
                    default: ill = 1'b1;
                endcase
            end
            7'b0000011, 7'b0100011: begin eb = im; res = a + im; end
            7'b1100011: begin
                br = 1'b1; eop = 4'b0110; res = a - b;
                case (f3)
                    3'b000: tk = (a == b);
                    3'b001: tk = (a != b);
                    3'b100: begin tk = ($signed(a) <  $signed(b)); ea[63] = ~a[63]; eb[63] = ~b[63]; end
                    3'b101: begin tk = ($signed(a) >= $signed(b)); ea[63] = ~a[63]; eb[63] = ~b[63]; end
                    3'b110: tk = (a < b);
                    3'b111: tk = (a >= b);
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin res = 64'd0; br = 1'b0; tk = 1'b0; end
    endtask

    // Model state: operation in flight, result visible, expected outputs and ALU drive.
    bit          m_busy = 1'b0;
    bit          m_valid = 1'b0;
    logic [63:0] m_res = 64'd0;
    logic        m_br = 1'b0, m_tk = 1'b0, m_ill = 1'b0;
    logic [63:0] m_a = 64'd0, m_b = 64'd0;
    logic [3:0]  m_op = 4'd0;

    task automatic model_update();
        logic [63:0] r, ea, eb;
        logic        br, tk, ill;
        logic [3:0]  eop;
        if (!reset_n) begin
            m_busy = 1'b0; m_valid = 1'b0;
            m_a = 64'd0; m_b = 64'd0; m_op = 4'd0;
        end else if (m_valid) begin
            if (out_ready) begin m_valid = 1'b0; m_busy = 1'b0; end
        end else if (m_busy) begin
            m_valid = 1'b1;
        end else if (in_valid) begin
            ref_exec(opcode, funct3, funct7_5, rs1_data, rs2_data, imm, r, br, tk, ill, ea, eb, eop);
            m_busy = 1'b1;
            m_res = r; m_br = br; m_tk = tk; m_ill = ill;
            if (ill) m_valid = 1'b1;
            else begin m_a = ea; m_b = eb; m_op = eop; end
        end
    endtask

    // Compare process: every falling edge, DUT against model.
    always @(negedge clk) begin
        check("in_ready", 64'(in_ready), 64'(reset_n && !m_busy));
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("alu_a", alu_a, m_a);
        check("alu_b", alu_b, m_b);
        check("alu_op", 64'(alu_op), 64'(m_op));
        if (m_valid) begin
            check("out_result", out_result, m_res);
            check("out_branch", 64'(out_branch), 64'(m_br));
            check("out_taken", 64'(out_taken), 64'(m_tk));
            check("out_illegal", 64'(out_illegal), 64'(m_ill));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] im);
        opcode = opc; funct3 = f3; funct7_5 = f75;
        rs1_data = a; rs2_data = b; imm = im;
        in_valid = 1'b1;
    endtask

    // Called one cycle after the accept edge; waits for out_valid, holds, then transfers.
    task automatic finish_op(input bit hold_iv, input int hold, output int lat,
                             output logic [63:0] r, output logic br, output logic tk, output logic ill);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 6) begin tick(); lat++; end
        check("valid_timeout", 64'(out_valid), 64'd1);
        r = out_result; br = out_branch; tk = out_taken; ill = out_illegal;
        in_valid = hold_iv;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (hold_iv) check("hold_no_accept", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("ready_after_xfer", 64'(in_ready), 64'd1);
    endtask

    task automatic run_op(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                          input logic [63:0] a, input logic [63:0] b, input logic [63:0] im,
                          output int lat, output logic [63:0] r, output logic br,
                          output logic tk, output logic ill);
        drive(opc, f3, f75, a, b, im);
        tick();
        finish_op(1'b0, 0, lat, r, br, tk, ill);
    endtask

    initial begin
        int          lat;
        logic [63:0] r;
        logic        br, tk, ill;

        reset_n = 1'b0; out_ready = 1'b0;
        drive(7'b0110011, 3'b000, 1'b0, 64'd5, 64'd7, 64'd0);
        @(negedge clk); #1;
        repeat (2) tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_alu_op", 64'(alu_op), 64'd0);
        check("rst_out_result", out_result, 64'd0);
        check("rst_alu_a", alu_a, 64'd0);

        // ADD accepted on the first edge after release, in_valid held through reset.
        reset_n = 1'b1;
        tick();
        check("add_alu_op", 64'(alu_op), 64'h2);
        finish_op(1'b0, 0, lat, r, br, tk, ill);
        check("add_latency", 64'(lat), 64'd2);
        check("add_result", r, 64'd12);
        check("add_branch", 64'(br), 64'd0);

        run_op(7'b0110011, 3'b000, 1'b1, 64'd5, 64'd7, 64'd0, lat, r, br, tk, ill);
        check("sub_result", r, 64'hFFFF_FFFF_FFFF_FFFE);

        run_op(7'b1100011, 3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, lat, r, br, tk, ill);
        check("blt_taken", 64'(tk), 64'd1);
        check("blt_alu_a", alu_a, 64'h7FFF_FFFF_FFFF_FFFF);
        check("blt_alu_b", alu_b, 64'h8000_0000_0000_0001);

        run_op(7'b1100011, 3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, lat, r, br, tk, ill);
        check("bltu_taken", 64'(tk), 64'd0);

        run_op(7'b1100011, 3'b000, 1'b0, 64'h1234, 64'h1234, 64'd0, lat, r, br, tk, ill);
        check("beq_taken", 64'(tk), 64'd1);
        check("beq_branch", 64'(br), 64'd1);

        run_op(7'b1100011, 3'b001, 1'b0, 64'h1234, 64'h1234, 64'd0, lat, r, br, tk, ill);
        check("bne_taken", 64'(tk), 64'd0);
        check("bne_branch", 64'(br), 64'd1);

        run_op(7'b0110111, 3'b000, 1'b0, 64'd9, 64'd9, 64'd9, lat, r, br, tk, ill);
        check("lui_latency", 64'(lat), 64'd1);
        check("lui_illegal", 64'(ill), 64'd1);
        check("lui_result", r, 64'd0);
        check("lui_alu_op_kept", 64'(alu_op), 64'h6);

        // Back-pressure with in_valid held.
        drive(7'b0010011, 3'b000, 1'b0, 64'd3, 64'd0, 64'd4);
        tick();
        finish_op(1'b1, 4, lat, r, br, tk, ill);
        check("addi_result", r, 64'd7);

        // Reset during EXEC discards the result.
        drive(7'b0110011, 3'b111, 1'b0, 64'hF0, 64'h3C, 64'd0);
        tick();
        in_valid = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("exec_rst_no_valid", 64'(out_valid), 64'd0);
        end

        // Randomized traffic with back-pressure and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            case ($urandom % 8)
                0: opcode = 7'b0110011;
                1: opcode = 7'b0010011;
                2: opcode = 7'b0000011;
                3: opcode = 7'b0100011;
                4, 5: opcode = 7'b1100011;
                6: opcode = 7'b0110111;
                default: opcode = 7'($urandom);
            endcase
            funct3   = 3'($urandom);
            funct7_5 = 1'($urandom);
            rs1_data = {$urandom, $urandom};
            case ($urandom % 4)
                0: rs2_data = rs1_data;
                1: rs2_data = 64'($urandom % 64);
                default: rs2_data = {$urandom, $urandom};
            endcase
            if (($urandom % 8) == 0) rs1_data[63] = ~rs2_data[63];
            imm = {$urandom, $urandom};
            if ($urandom % 2 == 0) imm[11:6] = 6'd0;
            in_valid  = 1'($urandom % 3 != 0);
            out_ready = 1'($urandom % 2);
            reset_n   = 1'($urandom % 300 != 0);
            tick();
        end
        reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Issue-side controller for the 64-bit ALU: accepts one decoded RV64 integer/branch instruction per handshake, and translates it into the ALU's 4-bit `ALUOp` and operands. It samples the ALU's `Result`, `ZERO` and `Is_greater` outputs and returns a registered result plus a branch decision on a valid/ready output channel. It sits between the decode stage and the combinational ALU, which it drives directly.

## Interface
- `DATA_W`, 64: operand/result width; must match the ALU.
- `OP_W`, 4: ALUOp width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: instruction offered.
- `in_ready` out 1: controller can accept.
- `opcode` in 7: instr[6:0].
- `funct3` in 3: instr[14:12].
- `funct7_5` in 1: instr[30].
- `rs1_data` in DATA_W: source 1.
- `rs2_data` in DATA_W: source 2.
- `imm` in DATA_W: sign-extended immediate.
- `alu_a` out DATA_W: to ALU `a`.
- `alu_b` out DATA_W: to ALU `b`.
- `alu_op` out OP_W: to ALU `ALUOp`.
- `alu_result` in DATA_W: from ALU `Result`.
- `alu_zero` in 1: from ALU `ZERO`.
- `alu_gt` in 1: from ALU `Is_greater`, which is an unsigned a>b.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts.
- `out_result` out DATA_W: sampled ALU result.
- `out_branch` out 1: instruction was a branch.
- `out_taken` out 1: branch condition true.
- `out_illegal` out 1: unsupported encoding.

## Operation
- **ALUOp codes:**
  - AND = 0000
  - OR = 0001
  - ADD = 0010
  - SUB = 0110
  - NOR = 1100
  - SLL = 0111
- **R-type (0110011):**
  - f3=000: ADD if f7_5=0, SUB if f7_5=1.
  - f3=111: AND.
  - f3=110: OR.
  - f3=001 with f7_5=0: SLL.
  - Operands: a=rs1, b=rs2.
- **I-type ALU (0010011):** same f3 map using ADD/AND/OR/SLL; b=imm. SLLI requires imm[11:6]=0, otherwise illegal.
- **Load (0000011) and Store (0100011):** ADD, a=rs1, b=imm (address generation).
- **Branch (1100011):** SUB, a=rs1, b=rs2, `out_branch`=1. Taken conditions:
  - BEQ (000): zero.
  - BNE (001): !zero.
  - BLTU (110): !gt & !zero.
  - BGEU (111): gt | zero.
  - BLT (100) / BGE (101): same conditions as BLTU/BGEU, but a and b are driven with bit DATA_W-1 inverted. This makes the unsigned `alu_gt` a signed compare; equality is unaffected.
- **Illegal:** any other encoding sets `out_illegal`=1, `out_result`=0, `out_branch`=0, `out_taken`=0. The ALU is not exercised.
- **Non-branch instructions:** `out_taken`=0.
- **States:**
  - IDLE: `in_ready`=1. `in_valid` moves to EXEC, or to DONE if illegal.
  - EXEC: one cycle; `alu_*` are stable from registers.
  - DONE: `out_valid`=1. `out_ready` moves to IDLE.
- `alu_a`, `alu_b`, `alu_op` are registers loaded at accept. They hold their value through DONE and IDLE and do not toggle without a new accept.

## Timing
- **Reset values (all asynchronous on `reset_n`=0):**
  - state IDLE.
  - `alu_a`=0, `alu_b`=0, `alu_op`=0000.
  - `out_valid`=0, `out_result`=0, `out_branch`=0, `out_taken`=0, `out_illegal`=0.
- `in_ready` is combinational from state: 1 in IDLE after reset release, 0 while `reset_n`=0.
- **Accept:** at a rising edge with `in_valid & in_ready` (cycle 0).
  - Legal instruction: EXEC in cycle 1. Outputs are registered at the end of cycle 1; `out_valid`=1 from cycle 2.
  - Illegal instruction: `out_valid`=1 from cycle 1.
- **Output hold:** `out_*` stay stable while `out_valid & !out_ready`.
- **Transfer:** on the edge with `out_valid & out_ready`, `out_valid` falls and `in_ready` rises in the next cycle.
- No overlap between operations: peak throughput is one op per 3 cycles (legal), or 2 cycles (illegal).
- `in_valid` is ignored outside IDLE. Inputs are sampled only at accept.
- `reset_n` asserted mid-operation: immediate return to IDLE and the reset values; the in-flight result is discarded.

## Structure
- Shared package `alu_pkg` holds:
  - the ALUOp constants above;
  - opcode constants: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH;
  - the branch funct3 constants;
  - a 2-bit state encoding: IDLE=00, EXEC=01, DONE=10.
- One combinational sub-module, `alu_issue_decode`. It takes opcode, f3, f7_5 and imm[11:6] and produces alu_op, b_sel_imm, flip_msb, is_branch, br_cond[2:0] and illegal.

## Test plan
- Reset with `in_valid`=1 held: all outputs 0 and `in_ready`=0 during reset. After release, accept occurs on the first edge.
- ADD rs1=5, rs2=7 -> `alu_op`=0010; `out_valid` at cycle 2 with `out_result`=12, `out_branch`=0. SUB with the same operands -> `out_result`=0xFFFF_FFFF_FFFF_FFFE.
- BLT rs1=0xFFFF_FFFF_FFFF_FFFF (-1), rs2=1 -> `alu_a` MSB inverted; `out_taken`=1. BLTU with the same operands -> `out_taken`=0.
- BEQ rs1=rs2=0x1234 -> `out_taken`=1. BNE with the same operands -> `out_taken`=0. Both give `out_branch`=1.
- Opcode 0110111 (LUI) -> `out_illegal`=1 at cycle 1; `alu_op` is unchanged from the previous op.
- `out_ready`=0 for 4 cycles with `in_valid` held -> outputs stable, `in_ready`=0, no second accept. `reset_n` pulsed in EXEC -> `out_valid` never rises.
